addsub_pipe_n: RTL and testbench

Pipelined, parametrised two's-complement adder/subtractor with signed/unsigned mode, per-operation add/sub select, overflow and carry flags, and a valid/ready handshake on both sides. The carry chain is split into `STAGES` equal segments, with one register boundary per segment, so wide operands close timing at full clock rate. It sits in the library arithmetic layer as the drop-in successor to the single-stage subtractor. Datapath and ALU blocks use it for streaming add/sub at one result per cycle.

---
 rtl/addsub_pipe_n.sv | 151 +++++++++++++++
 tb/tb_addsub_pipe_n.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe_n.sv
// Pipelined N-bit two's-complement adder/subtractor; the carry chain is cut into STAGES registered segments.
// Define ADDSUB_PIPE_SAT_EN to clamp data_o on overflow (flags still report the raw condition).
module addsub_pipe_n #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         op_i,
  input  logic         sign_i,
  input  logic [N-1:0] data0_i,
  input  logic [N-1:0] data1_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] data_o,
  output logic         over_o,
  output logic         carry_o
);

  localparam int W    = N / STAGES;
  localparam int LAST = STAGES - 1;

`ifdef ADDSUB_PIPE_SAT_EN
  function automatic logic [N-1:0] sat_value(input logic sign, input logic op, input logic a_msb);
    logic [N-1:0] v;
    if (sign) begin
      if (a_msb) v = {1'b1, {(N-1){1'b0}}};
      else       v = {1'b0, {(N-1){1'b1}}};
    end else if (op) begin
      v = {N{1'b0}};
    end else begin
      v = {N{1'b1}};
    end
    return v;
  endfunction
`endif

  // Each stage register carries the full operands, the partial sum and the segment carry.
  logic [N-1:0] a_r     [STAGES];
  logic [N-1:0] b_r     [STAGES];
  logic [N-1:0] sum_r   [STAGES];
  logic         carry_r [STAGES];
  logic         op_r    [STAGES];
  logic         sign_r  [STAGES];
  logic         valid_r [STAGES];
  logic         over_r;

  logic [N-1:0] a_src_s     [STAGES];
  logic [N-1:0] b_src_s     [STAGES];
  logic [N-1:0] sum_src_s   [STAGES];
  logic [N-1:0] sum_nxt_s   [STAGES];
  logic         cin_s       [STAGES];
  logic         cout_s      [STAGES];
  logic         op_src_s    [STAGES];
  logic         sign_src_s  [STAGES];
  logic         valid_src_s [STAGES];
  logic [W:0]   seg_s;
  logic         cmsb_s;
  logic         over_s;
  logic [N-1:0] final_s;
  logic         advance_s;

  assign advance_s   = ~valid_r[LAST] | out_ready_i;
  assign in_ready_o  = advance_s;
  assign out_valid_o = valid_r[LAST];
  assign data_o      = sum_r[LAST];
  assign carry_o     = carry_r[LAST];
  assign over_o      = over_r;

  // Stage inputs: stage 0 takes the new beat (data1 inverted for subtract), later stages take the previous register.
  always_comb begin
    a_src_s[0]     = data0_i;
    b_src_s[0]     = op_i ? ~data1_i : data1_i;
    sum_src_s[0]   = {N{1'b0}};
    cin_s[0]       = op_i;
    op_src_s[0]    = op_i;
    sign_src_s[0]  = sign_i;
    valid_src_s[0] = in_valid_i;
    for (int s = 1; s < STAGES; s++) begin
      a_src_s[s]     = a_r[s-1];
      b_src_s[s]     = b_r[s-1];
      sum_src_s[s]   = sum_r[s-1];
      cin_s[s]       = carry_r[s-1];
      op_src_s[s]    = op_r[s-1];
      sign_src_s[s]  = sign_r[s-1];
      valid_src_s[s] = valid_r[s-1];
    end
  end

  // Segment adders: stage s fills bits [s*W +: W] of the partial sum.
  always_comb begin
    seg_s = {(W+1){1'b0}};
    for (int s = 0; s < STAGES; s++) begin
      seg_s = {1'b0, a_src_s[s][s*W +: W]} + {1'b0, b_src_s[s][s*W +: W]} + {{W{1'b0}}, cin_s[s]};
      sum_nxt_s[s]           = sum_src_s[s];
      sum_nxt_s[s][s*W +: W] = seg_s[W-1:0];
      cout_s[s]              = seg_s[W];
    end
  end

  // Final-stage flags and optional clamp, resolved before the output register.
  always_comb begin
    cmsb_s = a_src_s[LAST][N-1] ^ b_src_s[LAST][N-1] ^ sum_nxt_s[LAST][N-1];
    if (sign_src_s[LAST]) begin
      over_s = cmsb_s ^ cout_s[LAST];
    end else if (op_src_s[LAST]) begin
      over_s = ~cout_s[LAST];
    end else begin
      over_s = cout_s[LAST];
    end
`ifdef ADDSUB_PIPE_SAT_EN
    if (over_s) begin
      final_s = sat_value(sign_src_s[LAST], op_src_s[LAST], a_src_s[LAST][N-1]);
    end else begin
      final_s = sum_nxt_s[LAST];
    end
`else
    final_s = sum_nxt_s[LAST];
`endif
  end

  // Pipeline registers: the whole pipe advances together or holds as a unit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < STAGES; s++) begin
        a_r[s]     <= {N{1'b0}};
        b_r[s]     <= {N{1'b0}};
        sum_r[s]   <= {N{1'b0}};
        carry_r[s] <= 1'b0;
        op_r[s]    <= 1'b0;
        sign_r[s]  <= 1'b0;
        valid_r[s] <= 1'b0;
      end
      over_r <= 1'b0;
    end else if (advance_s) begin
      for (int s = 0; s < STAGES; s++) begin
        a_r[s]     <= a_src_s[s];
        b_r[s]     <= b_src_s[s];
        sum_r[s]   <= (s == LAST) ? final_s : sum_nxt_s[s];
        carry_r[s] <= cout_s[s];
        op_r[s]    <= op_src_s[s];
        sign_r[s]  <= sign_src_s[s];
        valid_r[s] <= valid_src_s[s];
      end
      over_r <= over_s;
    end
  end

endmodule

// File: tb/tb_addsub_pipe_n.sv
// Self-checking bench for addsub_pipe_n (N=8, STAGES=2); expectations come from an integer-arithmetic model.
module tb_addsub_pipe_n;
  localparam int N      = 8;
  localparam int STAGES = 2;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, op, sign, out_valid, out_ready, over, carry;
  logic [7:0] d0, d1, dout;
  int         checks = 0;
  int         errors = 0;
  logic [9:0] exp_q [$];

  // Test-plan vectors with hand-derived results.
  logic [7:0] ta  [6] = '{8'h05, 8'h03, 8'h7F, 8'h80, 8'hFF, 8'hFF};
  logic [7:0] tb_ [6] = '{8'h03, 8'h05, 8'h01, 8'h01, 8'h01, 8'h01};
  logic       top [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       tsg [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] td  [6] = '{8'h02, 8'hFE, 8'h80, 8'h7F, 8'h00, 8'h00};
  logic [7:0] tds [6] = '{8'h02, 8'h00, 8'h7F, 8'h80, 8'h00, 8'hFF};
  logic       tov [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic       tcy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;

  addsub_pipe_n #(.N(N), .STAGES(STAGES)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .sign_i(sign), .data0_i(d0), .data1_i(d1),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .data_o(dout), .over_o(over), .carry_o(carry)
  );

  // Returns {data, over, carry} from integer arithmetic on the operands.
  function automatic logic [9:0] ref_model(input logic op_v, input logic sign_v,
                                           input logic [7:0] a, input logic [7:0] b);
    int ua, ub, ur, sa, sb, sr;
    logic ov, cy;
    logic [7:0] d;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ur = op_v ? (ua - ub) : (ua + ub);
    sr = op_v ? (sa - sb) : (sa + sb);
    d  = 8'(ur);
    cy = op_v ? (ua >= ub) : (ur > 255);
    if (sign_v) ov = (sr > 127) || (sr < -128);
    else        ov = op_v ? (ua < ub) : (ur > 255);
`ifdef ADDSUB_PIPE_SAT_EN
    if (ov) begin
      if (sign_v) d = (sa >= 0) ? 8'h7F : 8'h80;
      else        d = op_v ? 8'h00 : 8'hFF;
    end
`endif
    return {d, ov, cy};
  endfunction

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; op = 1'b0; sign = 1'b0; d0 = 8'h00; d1 = 8'h00; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", dout); end
    checks++; if (over !== 1'b0) begin errors++; $display("FAIL reset_over got=%b exp=0", over); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b exp=0", carry); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    int lat;
    logic [7:0] expd;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1;
      op = top[i]; sign = tsg[i]; d0 = ta[i]; d1 = tb_[i];
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
`ifdef ADDSUB_PIPE_SAT_EN
      expd = tds[i];
`else
      expd = td[i];
`endif
      checks++; if (lat != STAGES) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, STAGES); end
      checks++; if (dout !== expd) begin errors++; $display("FAIL dir%0d_data got=%h exp=%h", i, dout, expd); end
      checks++; if (over !== tov[i]) begin errors++; $display("FAIL dir%0d_over got=%b exp=%b", i, over, tov[i]); end
      checks++; if (carry !== tcy[i]) begin errors++; $display("FAIL dir%0d_carry got=%b exp=%b", i, carry, tcy[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] expv [4];
    logic       want;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        want = (c >= 2 && c <= 5);
        checks++; if (out_valid !== want) begin errors++; $display("FAIL b2b_valid_c%0d got=%b exp=%b", c, out_valid, want); end
        if (want && out_valid === 1'b1) begin
          checks++;
          if ({dout, over, carry} !== expv[c-2]) begin
            errors++; $display("FAIL b2b_result%0d got=%h exp=%h", c-2, {dout, over, carry}, expv[c-2]);
          end
        end
      end
      if (c < 4) begin
        in_valid = 1'b1; op = 1'(c); sign = 1'(c >> 1); d0 = 8'($urandom); d1 = 8'($urandom);
        expv[c] = ref_model(op, sign, d0, d1);
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  // Streams n_beats through a scoreboard; fixed 3-cycle stall when rnd=0, random valid/ready when rnd=1.
  task automatic test_stream(input int n_beats, input bit rnd);
    int sent, recv, cyc;
    logic held, saw_drop;
    logic [9:0] held_v, got, expv;
    sent = 0; recv = 0; cyc = 0; held = 1'b0; saw_drop = 1'b0; held_v = 10'h000;
    exp_q.delete();
    while ((sent < n_beats || recv < n_beats) && cyc < 4000) begin
      @(negedge clk);
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      else     out_ready = !(cyc >= 3 && cyc < 6);
      #1;
      got = {dout, over, carry};
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || got !== held_v) begin
          errors++; $display("FAIL stall_hold got=%b/%h exp=1/%h", out_valid, got, held_v);
        end
      end
      held   = out_valid & ~out_ready;
      held_v = got;
      if (out_valid && !out_ready) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
        saw_drop = 1'b1;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra_beat got=%h exp=none", got);
        end else begin
          expv = exp_q.pop_front();
          if (got !== expv) begin errors++; $display("FAIL stream_beat%0d got=%h exp=%h", recv, got, expv); end
        end
        recv++;
      end
      if (sent < n_beats && (!rnd || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1; op = 1'($urandom); sign = 1'($urandom); d0 = 8'($urandom); d1 = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(op, sign, d0, d1));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (recv != n_beats || sent != n_beats || exp_q.size() != 0) begin
      errors++; $display("FAIL stream_count got=sent%0d/recv%0d/left%0d exp=%0d", sent, recv, exp_q.size(), n_beats);
    end
    if (!rnd) begin
      checks++; if (!saw_drop) begin errors++; $display("FAIL bp_ready_drop got=0 exp=1"); end
    end
  endtask

  task automatic test_reset_midflight;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; op = 1'b0; sign = 1'b0; d0 = 8'h11; d1 = 8'h22;
    @(negedge clk);
    op = 1'b1; d0 = 8'h44; d1 = 8'h33;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rstmid_data got=%h exp=00", dout); end
    checks++; if (over !== 1'b0 || carry !== 1'b0) begin errors++; $display("FAIL rstmid_flags got=%b%b exp=00", over, carry); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ghost_c%0d got=%b exp=0", c, out_valid); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stream(6, 1'b0);
    test_reset_midflight();
    test_stream(200, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
